// File: rtl/pa_add.sv
// pa_add: registered WIDTH-bit ripple-carry adder, {c,s} = a + b + ci, one-cycle latency.
// Optional overflow output ovf is built only when PA_ADD_OVF_EN is defined.
module pa_add #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic             c
`ifdef PA_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  logic [WIDTH-1:0] p_s;
  logic [WIDTH-1:0] g_s;
  logic [WIDTH-1:0] sum_s;
  logic [WIDTH:0]   cy_s;

  logic [WIDTH-1:0] s_d, s_q;
  logic             c_d, c_q;
  logic             out_valid_d, out_valid_q;

  assign cy_s[0] = ci;

  // One full-adder cell per bit; cy_s ripples from bit 0 up to bit WIDTH.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign p_s[i]    = a[i] ^ b[i];
    assign g_s[i]    = a[i] & b[i];
    assign sum_s[i]  = p_s[i] ^ cy_s[i];
    assign cy_s[i+1] = g_s[i] | (p_s[i] & cy_s[i]);
  end

`ifdef PA_ADD_OVF_EN
  logic ovf_d, ovf_q;
`endif

  // Next-state: capture a new result on in_valid, otherwise hold s/c.
  always_comb begin
    s_d         = s_q;
    c_d         = c_q;
    out_valid_d = 1'b0;
`ifdef PA_ADD_OVF_EN
    ovf_d       = ovf_q;
`endif
    if (in_valid) begin
      s_d         = sum_s;
      c_d         = cy_s[WIDTH];
      out_valid_d = 1'b1;
`ifdef PA_ADD_OVF_EN
      ovf_d       = cy_s[WIDTH] ^ cy_s[WIDTH-1];
`endif
    end else begin
      out_valid_d = 1'b0;
    end
  end

  // Result registers; reset wins over a simultaneous in_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q         <= {WIDTH{1'b0}};
      c_q         <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef PA_ADD_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      s_q         <= s_d;
      c_q         <= c_d;
      out_valid_q <= out_valid_d;
`ifdef PA_ADD_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign s         = s_q;
  assign c         = c_q;
  assign out_valid = out_valid_q;
`ifdef PA_ADD_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_pa_add.sv
// Directed bench for pa_add at WIDTH=4: fixed vectors, reset/hold cases, then all 512 inputs streamed.
module tb_pa_add;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic       ci;
  logic       out_valid;
  logic [3:0] s;
  logic       c;
`ifdef PA_ADD_OVF_EN
  logic       ovf;
`endif

  int vectors;
  int fails;

  pa_add #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .out_valid (out_valid),
    .s         (s),
    .c         (c)
`ifdef PA_ADD_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one set of inputs, let one rising edge pass, then settle 1 time unit.
  task automatic step(input logic r, input logic v, input logic [3:0] aa,
                      input logic [3:0] bb, input logic cc);
    rst      = r;
    in_valid = v;
    a        = aa;
    b        = bb;
    ci       = cc;
    @(posedge clk);
    #1;
  endtask

  // Compare {out_valid, c, s} against the expected 6-bit value.
  task automatic chk(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {out_valid, c, s};
    vectors++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: got {ov,c,s}=%b required %b", tag, obs, exp);
      end
  endtask

`ifdef PA_ADD_OVF_EN
  task automatic chk_ovf(input string tag, input logic exp);
    vectors++;
    assert (ovf === exp)
      else begin
        fails++;
        $error("FAIL %s: got ovf=%b required %b", tag, ovf, exp);
      end
  endtask
`endif

  initial begin
    logic [4:0] full;
    logic [3:0] ea;
    logic [3:0] eb;
    logic       ec;
    vectors = 0;
    fails   = 0;

    step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
    chk("reset", 6'b0_0_0000);
`ifdef PA_ADD_OVF_EN
    chk_ovf("reset_ovf", 1'b0);
`endif

    step(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0); chk("zero",     6'b1_0_0000);
    step(1'b0, 1'b1, 4'b0101, 4'b0101, 1'b0); chk("mid",      6'b1_0_1010);
    step(1'b0, 1'b1, 4'b0101, 4'b0101, 1'b1); chk("mid_ci",   6'b1_0_1011);
    step(1'b0, 1'b1, 4'b1010, 4'b1010, 1'b0); chk("carry",    6'b1_1_0100);
`ifdef PA_ADD_OVF_EN
    chk_ovf("carry_ovf", 1'b1);
`endif
    step(1'b0, 1'b1, 4'b1111, 4'b1111, 1'b1); chk("max_ci",   6'b1_1_1111);
    step(1'b0, 1'b1, 4'b1111, 4'b1111, 1'b0); chk("max",      6'b1_1_1110);
    step(1'b0, 1'b1, 4'b1111, 4'b0000, 1'b1); chk("ripple",   6'b1_1_0000);

    step(1'b0, 1'b0, 4'($urandom), 4'($urandom), 1'($urandom)); chk("hold1", 6'b0_1_0000);
    step(1'b0, 1'b0, 4'($urandom), 4'($urandom), 1'($urandom)); chk("hold2", 6'b0_1_0000);

    step(1'b1, 1'b1, 4'b1111, 4'b0001, 1'b0); chk("rst_prio", 6'b0_0_0000);
    step(1'b0, 1'b1, 4'b0011, 4'b0100, 1'b0); chk("post_rst", 6'b1_0_0111);

    step(1'b0, 1'b1, 4'b1001, 4'b1001, 1'b0); chk("pre_mid",  6'b1_1_0010);
    step(1'b1, 1'b1, 4'b0110, 4'b0001, 1'b1); chk("mid_rst",  6'b0_0_0000);
    step(1'b0, 1'b0, 4'b0110, 4'b0001, 1'b1); chk("mid_idle", 6'b0_0_0000);

    for (int i = 0; i < 512; i++) begin
      ea   = i[3:0];
      eb   = i[7:4];
      ec   = i[8];
      full = {1'b0, ea} + {1'b0, eb} + {4'b0000, ec};
      step(1'b0, 1'b1, ea, eb, ec);
      chk($sformatf("exh_%0d", i), {1'b1, full});
`ifdef PA_ADD_OVF_EN
      chk_ovf($sformatf("exh_ovf_%0d", i), (ea[3] == eb[3]) && (full[3] != ea[3]));
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/pa_add.md
Name: pa_add

Overview:
- Parameterised parallel binary adder computing S = A + B + CI, with carry-out.
- Default width is 4 bits.
- Built as a chain of per-bit full adders; the result is registered on the single clock.
- Used as a leaf arithmetic block wherever a small synchronous adder with carry-in/carry-out is needed.

Parameters:
- WIDTH, 4, operand and sum width in bits (legal range 1..32).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies a, b, ci on the current edge.
- a  input  WIDTH  addend A, unsigned.
- b  input  WIDTH  addend B, unsigned.
- ci  input  1  carry-in.
- out_valid  output  1  high for one cycle when s and c hold a new result.
- s  output  WIDTH  registered sum bits [WIDTH-1:0].
- c  output  1  registered carry-out (bit WIDTH of the full result).

Behaviour:
- Datapath per bit i:
  - p[i] = a[i]^b[i]
  - g[i] = a[i]&b[i]
  - sum[i] = p[i]^cy[i]
  - cy[i+1] = g[i] | (p[i]&cy[i])
  - cy[0] = ci
  - Implemented as a generate loop of full-adder cells, i.e. a ripple chain.
- The combinational result {cy[WIDTH], sum} must equal a + b + ci exactly. The full range 0..2^(WIDTH+1)-1 is representable, so there is no truncation.
- Latency is one clock: inputs sampled at edge N with in_valid=1 appear on s/c at edge N, visible after edge N, with out_valid=1 for that cycle.
- in_valid=0 at an edge:
  - s and c hold their previous values.
  - out_valid=0.
- Back-to-back operation: in_valid may be high every cycle; throughput is one add per clock. There is no backpressure.
- Reset, at a rising edge with rst=1:
  - s=0, c=0, out_valid=0 (and ovf=0 if present).
  - rst takes priority over a simultaneous in_valid. An input presented in the same cycle as reset is discarded.
- Reset mid-stream: the pending result is lost. The first valid result after reset comes from the first in_valid edge with rst=0.
- Boundary cases:
  - All-ones operands with ci=1 give s=all-ones, c=1.
  - All-zero operands with ci=0 give s=0, c=0.
  - ci alone propagating through all-ones p (a=all-ones, b=0, ci=1) gives s=0, c=1. This is the full ripple path and must close timing at target frequency.
- X on a, b or ci while in_valid=0 must not disturb s or c.

Optional Feature:
- Macro: PA_ADD_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit): registered two's-complement overflow, cy[WIDTH] ^ cy[WIDTH-1].
  - ovf updates, holds and resets exactly like c.
- When undefined:
  - Port ovf does not exist.
  - No overflow logic is built.
  - All other behaviour is identical.

Test Plan:
- Reset then zero add: rst=1 for 2 cycles, then a=0000, b=0000, ci=0, in_valid=1 -> next cycle s=0000, c=0, out_valid=1.
- Mid-range, no carry: a=0101, b=0101, ci=0 -> s=1010, c=0. Same with ci=1 -> s=1011, c=0.
- Carry-out: a=1010, b=1010, ci=0 -> s=0100, c=1. With PA_ADD_OVF_EN, ovf=1.
- Maximum values: a=1111, b=1111, ci=1 -> s=1111, c=1. With ci=0 -> s=1110, c=1.
- Hold and reset priority:
  - in_valid=0 with random a/b -> s/c unchanged, out_valid=0.
  - rst=1 together with in_valid=1, a=1111, b=0001 -> s=0000, c=0, out_valid=0.
- Exhaustive/random: all 512 (a,b,ci) combinations streamed back-to-back at WIDTH=4 -> each cycle {c,s} equals a+b+ci of the previous cycle, with out_valid=1 continuously.
